// File: rtl/ram_sweep_ctrl.sv
// RAM sweep controller: writes a selectable data pattern across DEPTH words, or
// reads them back with each address held for RD_DIV cycles (single pass or looping).
module ram_sweep_ctrl #(
  parameter int unsigned          DATA_W  = 8,
  parameter int unsigned          ADDR_W  = 8,
  parameter int unsigned          DEPTH   = 256,
  parameter int unsigned          RD_DIV  = 10_000_000,
  parameter logic [DATA_W-1:0]    FIX_VAL = DATA_W'(8'hA5)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_flag,
  input  logic              rd_flag,
  input  logic [1:0]        pat_mode,
  input  logic              rd_loop,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              wr_done,
  output logic              rd_done
);

  localparam int unsigned HOLD_W = (RD_DIV > 1) ? $clog2(RD_DIV) : 1;
  localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(DEPTH - 1);
  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(RD_DIV - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

  state_e             r_state, w_state_d;
  logic [ADDR_W-1:0]  r_addr, w_addr_d;
  logic [HOLD_W-1:0]  r_hold_cnt, w_hold_cnt_d;
  logic [1:0]         r_pat, w_pat_d;
  logic               r_wr_done, w_wr_done_d;
  logic               r_rd_done, w_rd_done_d;
  logic [DATA_W-1:0]  w_addr_ext;

  // Address zero-extended or truncated to the data width.
  if (ADDR_W >= DATA_W) begin : g_addr_trunc
    assign w_addr_ext = r_addr[DATA_W-1:0];
  end else begin : g_addr_zext
    assign w_addr_ext = {{(DATA_W - ADDR_W){1'b0}}, r_addr};
  end

  // Next-state logic: flags take priority, then sweep advance and wrap.
  always_comb begin
    w_state_d    = r_state;
    w_addr_d     = r_addr;
    w_hold_cnt_d = r_hold_cnt;
    w_pat_d      = r_pat;
    w_wr_done_d  = 1'b0;
    w_rd_done_d  = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_addr_d     = '0;
        w_hold_cnt_d = '0;
        if (wr_flag) begin
          w_state_d = StWrite;
          w_pat_d   = pat_mode;
        end else if (rd_flag) begin
          w_state_d = StRead;
        end
      end
      StWrite: begin
        if (wr_flag) begin
          w_addr_d = '0;
          w_pat_d  = pat_mode;
        end else if (r_addr == AddrLast) begin
          w_state_d   = StIdle;
          w_addr_d    = '0;
          w_wr_done_d = 1'b1;
        end else begin
          w_addr_d = r_addr + ADDR_W'(1);
        end
      end
      StRead: begin
        if (wr_flag) begin
          // Abort the read; no rd_done for an abandoned pass.
          w_state_d    = StWrite;
          w_addr_d     = '0;
          w_hold_cnt_d = '0;
          w_pat_d      = pat_mode;
        end else if (rd_flag) begin
          w_addr_d     = '0;
          w_hold_cnt_d = '0;
        end else if (r_hold_cnt == HoldLast) begin
          w_hold_cnt_d = '0;
          if (r_addr == AddrLast) begin
            w_addr_d = '0;
            if (!rd_loop) begin
              w_state_d   = StIdle;
              w_rd_done_d = 1'b1;
            end
          end else begin
            w_addr_d = r_addr + ADDR_W'(1);
          end
        end else begin
          w_hold_cnt_d = r_hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        w_state_d    = StIdle;
        w_addr_d     = '0;
        w_hold_cnt_d = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_hold_cnt <= '0;
      r_pat      <= '0;
      r_wr_done  <= 1'b0;
      r_rd_done  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_addr     <= w_addr_d;
      r_hold_cnt <= w_hold_cnt_d;
      r_pat      <= w_pat_d;
      r_wr_done  <= w_wr_done_d;
      r_rd_done  <= w_rd_done_d;
    end
  end

  // Outputs decoded from registered state; write data forced to 0 outside WRITE.
  always_comb begin
    wr_en   = (r_state == StWrite);
    rd_en   = (r_state == StRead);
    busy    = wr_en | rd_en;
    addr    = r_addr;
    wr_done = r_wr_done;
    rd_done = r_rd_done;
    wr_data = '0;
    if (wr_en) begin
      unique case (r_pat)
        2'd0:    wr_data = w_addr_ext;
        2'd1:    wr_data = ~w_addr_ext;
        2'd2:    wr_data = FIX_VAL;
        default: wr_data = w_addr_ext ^ FIX_VAL;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_sweep_ctrl.sv
// Self-checking bench for ram_sweep_ctrl: directed scenarios then random flags,
// every cycle compared against a sweep-position reference model.
module tb_ram_sweep_ctrl;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned RD_DIV = 3;
  localparam logic [7:0]  FIX    = 8'hA5;

  logic              sys_clk   = 1'b0;
  logic              sys_rst_n = 1'b1;
  logic              wr_flag   = 1'b0;
  logic              rd_flag   = 1'b0;
  logic [1:0]        pat_mode  = 2'd0;
  logic              rd_loop   = 1'b0;
  logic              wr_en, rd_en, busy, wr_done, rd_done;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model: mode 0 idle, 1 write, 2 read; idx = cycles into the sweep.
  int         m_mode  = 0;
  int         m_idx   = 0;
  logic [1:0] m_pat   = 2'd0;
  bit         m_wdone = 1'b0;
  bit         m_rdone = 1'b0;

  ram_sweep_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .RD_DIV (RD_DIV),
    .FIX_VAL(FIX)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .wr_flag  (wr_flag),
    .rd_flag  (rd_flag),
    .pat_mode (pat_mode),
    .rd_loop  (rd_loop),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .wr_done  (wr_done),
    .rd_done  (rd_done)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [7:0] pat_of(input logic [1:0] p, input int a);
    logic [7:0] av;
    av = a[7:0];
    case (p)
      2'd0:    return av;
      2'd1:    return ~av;
      2'd2:    return FIX;
      default: return av ^ FIX;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int exp_addr;
    logic [7:0] exp_data;
    exp_addr = (m_mode == 1) ? m_idx : (m_mode == 2) ? m_idx / RD_DIV : 0;
    exp_data = (m_mode == 1) ? pat_of(m_pat, m_idx) : 8'h00;
    check("wr_en",   32'(wr_en),   32'(m_mode == 1));
    check("rd_en",   32'(rd_en),   32'(m_mode == 2));
    check("busy",    32'(busy),    32'(m_mode != 0));
    check("addr",    32'(addr),    32'(exp_addr));
    check("wr_data", 32'(wr_data), 32'(exp_data));
    check("wr_done", 32'(wr_done), 32'(m_wdone));
    check("rd_done", 32'(rd_done), 32'(m_rdone));
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_idx   = 0;
    m_pat   = 2'd0;
    m_wdone = 1'b0;
    m_rdone = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge();
    if (!sys_rst_n) begin
      model_reset();
      return;
    end
    m_wdone = 1'b0;
    m_rdone = 1'b0;
    if (wr_flag) begin
      m_mode = 1;
      m_idx  = 0;
      m_pat  = pat_mode;
    end else if (m_mode == 1) begin
      if (m_idx == DEPTH - 1) begin
        m_mode  = 0;
        m_idx   = 0;
        m_wdone = 1'b1;
      end else begin
        m_idx++;
      end
    end else if (rd_flag) begin
      m_mode = 2;
      m_idx  = 0;
    end else if (m_mode == 2) begin
      if (m_idx == DEPTH * RD_DIV - 1) begin
        m_idx = 0;
        if (!rd_loop) begin
          m_mode  = 0;
          m_rdone = 1'b1;
        end
      end else begin
        m_idx++;
      end
    end
  endtask

  // One clock: model at the edge, check just after, return on the falling edge.
  task automatic step();
    @(posedge sys_clk);
    model_edge();
    #1;
    check_all();
    @(negedge sys_clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_wr(input logic [1:0] pm);
    pat_mode = pm;
    wr_flag  = 1'b1;
    step();
    wr_flag  = 1'b0;
  endtask

  task automatic pulse_rd();
    rd_flag = 1'b1;
    step();
    rd_flag = 1'b0;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    step();
    sys_rst_n = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();
    steps(3);

    // Write sweep, address pattern.
    pulse_wr(2'd0);
    steps(5);

    // Inverted, XOR and fixed patterns with pat_mode toggled mid-sweep.
    pulse_wr(2'd1);
    pat_mode = 2'd2;
    steps(2);
    pat_mode = 2'd0;
    steps(4);
    pulse_wr(2'd3);
    pat_mode = 2'd1;
    steps(5);
    pulse_wr(2'd2);
    pat_mode = 2'd3;
    steps(5);

    // Single-pass read.
    rd_loop = 1'b0;
    pulse_rd();
    steps(14);

    // Looping read, then drop rd_loop while at address 1.
    rd_loop = 1'b1;
    pulse_rd();
    steps(20);
    for (int i = 0; i < 40 && (m_mode != 2 || m_idx / RD_DIV != 1); i++) step();
    check("reached_addr1", 32'(addr), 32'd1);
    rd_loop = 1'b0;
    steps(14);

    // Both flags together, rd_flag during write, wr_flag during read at addr 2.
    wr_flag  = 1'b1;
    rd_flag  = 1'b1;
    pat_mode = 2'd0;
    step();
    wr_flag  = 1'b0;
    rd_flag  = 1'b0;
    step();
    pulse_rd();
    steps(4);
    pulse_rd();
    for (int i = 0; i < 40 && (m_mode != 2 || m_idx / RD_DIV != 2); i++) step();
    check("read_at_addr2", 32'(addr), 32'd2);
    pulse_wr(2'd3);
    steps(6);

    // Reset mid-write at address 2.
    pulse_wr(2'd1);
    steps(2);
    check("write_at_addr2", 32'(addr), 32'd2);
    do_reset();
    steps(4);

    // Random stimulus.
    for (int i = 0; i < 800; i++) begin
      wr_flag  = ($urandom_range(0, 24) == 0);
      rd_flag  = ($urandom_range(0, 14) == 0);
      pat_mode = 2'($urandom_range(0, 3));
      rd_loop  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) begin
        wr_flag = 1'b0;
        rd_flag = 1'b0;
        do_reset();
      end else begin
        step();
      end
    end
    wr_flag = 1'b0;
    rd_flag = 1'b0;
    steps(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
